// File: rtl/timer_cnt_core_if.sv
// rtl/timer_cnt_core_if.sv - register-bank/detector side bundle of the timer counting core
interface timer_cnt_core_if #(
    parameter int CNT_WIDTH = 64,
    parameter int DIV_WIDTH = 4
);
    logic                 i_timer_en;
    logic                 i_div_en;
    logic [DIV_WIDTH-1:0] i_div_val;
    logic                 i_halt_detect;
    logic                 i_cnt_wr;
    logic [CNT_WIDTH-1:0] i_cnt_wdata;
    logic [CNT_WIDTH-1:0] i_cmp_val;
    logic                 i_int_en;
    logic                 i_int_clr;
    logic [CNT_WIDTH-1:0] o_cnt;
    logic                 o_int_st;
    logic                 o_interrupt;
    logic                 o_halt_ack;

    modport master (
        output i_timer_en, i_div_en, i_div_val, i_halt_detect, i_cnt_wr,
               i_cnt_wdata, i_cmp_val, i_int_en, i_int_clr,
        input  o_cnt, o_int_st, o_interrupt, o_halt_ack
    );

    modport slave (
        input  i_timer_en, i_div_en, i_div_val, i_halt_detect, i_cnt_wr,
               i_cnt_wdata, i_cmp_val, i_int_en, i_int_clr,
        output o_cnt, o_int_st, o_interrupt, o_halt_ack
    );
endinterface

// File: rtl/timer_cnt_core.sv
// rtl/timer_cnt_core.sv - prescaled wrap-around counter with sticky compare status and halt ack
module timer_cnt_core #(
    parameter int CNT_WIDTH = 64,
    parameter int DIV_WIDTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    timer_cnt_core_if.slave bus
);
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [7:0]           div_cnt;
    logic                 st_q;
    logic                 ack_q;
    logic [3:0]           exp_eff;
    logic [7:0]           limit;
    logic                 div_done;
    logic                 tick;
    logic                 match;

    // Exponents above 8 saturate, so the prescaler never needs more than 8 bits.
    always_comb begin
        exp_eff = 4'd8;
        if ({{(32-DIV_WIDTH){1'b0}}, bus.i_div_val} < 32'd8)
            exp_eff = 4'(bus.i_div_val);
        limit    = 8'((9'd1 << exp_eff) - 9'd1);
        div_done = (div_cnt >= limit);
        tick     = bus.i_timer_en & ~bus.i_halt_detect & (~bus.i_div_en | div_done);
        match    = (cnt_q == bus.i_cmp_val);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            div_cnt <= '0;
            st_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= bus.i_halt_detect;

            // >= rather than == lets a shrinking divider finish its period at once.
            if (!bus.i_timer_en || !bus.i_div_en)
                div_cnt <= '0;
            else if (!bus.i_halt_detect)
                div_cnt <= div_done ? 8'd0 : div_cnt + 8'd1;

            if (bus.i_cnt_wr)
                cnt_q <= bus.i_cnt_wdata;
            else if (tick)
                cnt_q <= cnt_q + 1'b1;

            if (match)
                st_q <= 1'b1;
            else if (bus.i_int_clr)
                st_q <= 1'b0;
        end
    end

    assign bus.o_cnt       = cnt_q;
    assign bus.o_int_st    = st_q;
    assign bus.o_interrupt = st_q & bus.i_int_en;
    assign bus.o_halt_ack  = ack_q;
endmodule

// File: tb/tb_timer_cnt_core.sv
// tb/tb_timer_cnt_core.sv - directed bench with cycle-level reference model for timer_cnt_core
module tb_timer_cnt_core;
    localparam int CW = 64;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_on = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    timer_cnt_core_if #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) bus ();

    timer_cnt_core #(.CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: elapsed cycles inside the current prescaler period; a period of
    // 2^e active cycles completes on its last cycle and yields one count.
    logic [CW-1:0] m_cnt;
    int            m_elapsed;
    logic          m_st;
    logic          m_ack;

    always @(posedge clk or posedge rst) begin : model
        int   e;
        int   period;
        logic tk;
        if (rst) begin
            m_cnt     = '0;
            m_elapsed = 0;
            m_st      = 1'b0;
            m_ack     = 1'b0;
        end else begin
            e      = (int'(bus.i_div_val) > 8) ? 8 : int'(bus.i_div_val);
            period = 1 << e;
            tk     = bus.i_timer_en && !bus.i_halt_detect &&
                     (!bus.i_div_en || (m_elapsed + 1 >= period));
            if (m_cnt == bus.i_cmp_val) m_st = 1'b1;
            else if (bus.i_int_clr)     m_st = 1'b0;
            if (!bus.i_timer_en || !bus.i_div_en)
                m_elapsed = 0;
            else if (!bus.i_halt_detect)
                m_elapsed = (m_elapsed + 1 >= period) ? 0 : m_elapsed + 1;
            if (bus.i_cnt_wr) m_cnt = bus.i_cnt_wdata;
            else if (tk)      m_cnt = m_cnt + 1'b1;
            m_ack = bus.i_halt_detect;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("mdl_cnt",       bus.o_cnt,       m_cnt);
            chk("mdl_int_st",    bus.o_int_st,    m_st);
            chk("mdl_interrupt", bus.o_interrupt, m_st & bus.i_int_en);
            chk("mdl_halt_ack",  bus.o_halt_ack,  m_ack);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.i_timer_en    = 1'b0;
        bus.i_div_en      = 1'b0;
        bus.i_div_val     = '0;
        bus.i_halt_detect = 1'b0;
        bus.i_cnt_wr      = 1'b0;
        bus.i_cnt_wdata   = '0;
        bus.i_cmp_val     = '1;
        bus.i_int_en      = 1'b0;
        bus.i_int_clr     = 1'b0;
        cyc(1);
        chk_on = 1'b1;
        chk("rst_cnt", bus.o_cnt, 0);
        chk("rst_st", bus.o_int_st, 0);
        cyc(1);

        rst = 1'b0;
        bus.i_timer_en = 1'b1;
        cyc(1); chk("basic_1", bus.o_cnt, 1);
        cyc(1); chk("basic_2", bus.o_cnt, 2);
        cyc(1); chk("basic_3", bus.o_cnt, 3);

        rst = 1'b1;
        #1;
        chk("rst_mid_cnt", bus.o_cnt, 0);
        chk("rst_mid_ack", bus.o_halt_ack, 0);
        cyc(2);
        rst = 1'b0;
        cyc(1); chk("restart_1", bus.o_cnt, 1);

        bus.i_cnt_wr = 1'b1; bus.i_cnt_wdata = '0;
        cyc(1); chk("load_zero", bus.o_cnt, 0);
        bus.i_cnt_wr = 1'b0; bus.i_div_en = 1'b1; bus.i_div_val = 4'd2;
        cyc(3); chk("div4_hold", bus.o_cnt, 0);
        cyc(1); chk("div4_tick", bus.o_cnt, 1);
        cyc(3); chk("div4_hold2", bus.o_cnt, 1);
        bus.i_div_val = 4'd0;
        cyc(1); chk("div_shrink", bus.o_cnt, 2);
        cyc(1); chk("div1_tick", bus.o_cnt, 3);
        bus.i_div_val = 4'd12;
        cyc(255); chk("div256_hold", bus.o_cnt, 3);
        cyc(1); chk("div256_tick", bus.o_cnt, 4);

        bus.i_div_val = 4'd1;
        cyc(1); chk("halt_pre", bus.o_cnt, 4);
        bus.i_halt_detect = 1'b1;
        cyc(1); chk("halt_cnt1", bus.o_cnt, 4); chk("halt_ack1", bus.o_halt_ack, 1);
        cyc(4); chk("halt_cnt5", bus.o_cnt, 4); chk("halt_ack5", bus.o_halt_ack, 1);
        bus.i_halt_detect = 1'b0;
        cyc(1); chk("halt_resume", bus.o_cnt, 5); chk("halt_ack_drop", bus.o_halt_ack, 0);

        bus.i_div_en = 1'b0; bus.i_cmp_val = 64'd100;
        bus.i_cnt_wr = 1'b1; bus.i_cnt_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
        cyc(1); chk("wrap_load", bus.o_cnt, 64'hFFFF_FFFF_FFFF_FFFE);
        bus.i_cnt_wr = 1'b0;
        cyc(1); chk("wrap_ones", bus.o_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1); chk("wrap_zero", bus.o_cnt, 0); chk("wrap_no_st", bus.o_int_st, 0);
        bus.i_cnt_wr = 1'b1; bus.i_cnt_wdata = 64'd50;
        cyc(1); chk("wr_beats_tick", bus.o_cnt, 50);

        bus.i_cmp_val = 64'd10; bus.i_cnt_wdata = 64'd8;
        cyc(1); chk("int_load", bus.o_cnt, 8);
        bus.i_cnt_wr = 1'b0;
        cyc(2); chk("int_at_cmp", bus.o_cnt, 10);
        bus.i_halt_detect = 1'b1;
        cyc(1); chk("int_st_set", bus.o_int_st, 1); chk("int_masked", bus.o_interrupt, 0);
        bus.i_int_en = 1'b1;
        #1; chk("int_unmasked", bus.o_interrupt, 1);
        bus.i_int_clr = 1'b1;
        cyc(1); chk("clr_while_match", bus.o_int_st, 1);
        bus.i_int_clr = 1'b0; bus.i_halt_detect = 1'b0;
        cyc(1); chk("int_cnt11", bus.o_cnt, 11); chk("int_st_held", bus.o_int_st, 1);
        bus.i_int_clr = 1'b1;
        cyc(1); chk("clr_done", bus.o_int_st, 0);
        bus.i_int_clr = 1'b0;

        bus.i_timer_en = 1'b0; bus.i_cmp_val = 64'd20;
        bus.i_cnt_wr = 1'b1; bus.i_cnt_wdata = 64'd20;
        cyc(1); chk("coll_load", bus.o_cnt, 20); chk("coll_pre_st", bus.o_int_st, 0);
        bus.i_cnt_wr = 1'b0; bus.i_int_clr = 1'b1;
        cyc(1); chk("coll_set_wins", bus.o_int_st, 1);
        bus.i_int_clr = 1'b0; bus.i_int_en = 1'b0;
        #1; chk("mask_no_clear", bus.o_int_st, 1); chk("mask_irq", bus.o_interrupt, 0);
        cyc(2);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
